// File: rtl/ks_note_sequencer.sv
// Step sequencer driving the Karplus-Strong string voice: pluck strobe and period select at a fixed tempo.
// Optional macro KS_SEQ_ACCENT_EN adds a per-step accent bit and the accent_o output.
module ks_note_sequencer #(
  parameter int unsigned NUM_STEPS = 8,
  parameter int unsigned PERIOD_W  = 4,
  parameter int unsigned TEMPO_W   = 16,
  parameter int unsigned GATE_W    = 8,
  localparam int unsigned STEP_W   = $clog2(NUM_STEPS),
`ifdef KS_SEQ_ACCENT_EN
  localparam int unsigned DATA_W   = PERIOD_W + 2
`else
  localparam int unsigned DATA_W   = PERIOD_W + 1
`endif
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic                restart_i,
  input  logic [TEMPO_W-1:0]  tempo_i,
  input  logic [GATE_W-1:0]   gate_len_i,
  input  logic [STEP_W-1:0]   last_step_i,
  input  logic                wr_en_i,
  input  logic [STEP_W-1:0]   wr_addr_i,
  input  logic [DATA_W-1:0]   wr_data_i,
  output logic                pluck_o,
  output logic [PERIOD_W-1:0] period_o,
  output logic [STEP_W-1:0]   step_o,
  output logic                step_tick_o,
  output logic                busy_o
`ifdef KS_SEQ_ACCENT_EN
  ,
  output logic                accent_o
`endif
);

  typedef enum logic {IDLE, RUN} state_e;

  state_e              state_q, state_d;
  logic [TEMPO_W-1:0]  tempo_cnt_q;
  logic [GATE_W-1:0]   gate_cnt_q;
  logic [DATA_W-1:0]   mem [NUM_STEPS];

  logic [TEMPO_W-1:0]  t_eff;
  logic                tempo_done;
  logic                gate_done;
  logic                start;
  logic                from_zero;
  logic [STEP_W-1:0]   next_step;
  logic [DATA_W-1:0]   rd_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    start      = 1'b0;
    from_zero  = 1'b0;
    t_eff      = (tempo_i == '0) ? TEMPO_W'(1) : tempo_i;
    tempo_done = (tempo_cnt_q >= t_eff);
    // Gate is also cut one clock before the step ends so every sounding step has a low cycle.
    gate_done  = (gate_cnt_q >= gate_len_i) || (tempo_cnt_q >= (t_eff - TEMPO_W'(1)));
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d   = RUN;
          start     = 1'b1;
          from_zero = 1'b1;
        end
      end
      RUN: begin
        if (!enable_i) begin
          state_d = IDLE;
        end else if (restart_i) begin
          start     = 1'b1;
          from_zero = 1'b1;
        end else if (tempo_done) begin
          start = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (from_zero || (step_o >= last_step_i)) next_step = '0;
    else                                      next_step = step_o + STEP_W'(1);
    rd_data = mem[next_step];
  end

  assign busy_o = (state_q == RUN);

  // Step start reads mem before this edge's write lands, so a same-cycle write is seen next time.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) mem[i] <= '0;
      tempo_cnt_q <= '0;
      gate_cnt_q  <= '0;
      pluck_o     <= 1'b0;
      period_o    <= '0;
      step_o      <= '0;
      step_tick_o <= 1'b0;
`ifdef KS_SEQ_ACCENT_EN
      accent_o    <= 1'b0;
`endif
    end else begin
      if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
      step_tick_o <= start;
      if (start) begin
        step_o      <= next_step;
        period_o    <= rd_data[PERIOD_W-1:0];
        pluck_o     <= ~rd_data[PERIOD_W];
`ifdef KS_SEQ_ACCENT_EN
        accent_o    <= rd_data[PERIOD_W+1];
`endif
        tempo_cnt_q <= '0;
        gate_cnt_q  <= '0;
      end else if ((state_q == RUN) && enable_i) begin
        tempo_cnt_q <= tempo_cnt_q + TEMPO_W'(1);
        if (pluck_o) begin
          if (gate_done) pluck_o    <= 1'b0;
          else           gate_cnt_q <= gate_cnt_q + GATE_W'(1);
        end
      end else begin
        pluck_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ks_note_sequencer.sv
// Randomized self-checking bench for ks_note_sequencer against a step-position reference model.
// Honours KS_SEQ_ACCENT_EN when defined for the build.
module tb_ks_note_sequencer;

`ifdef KS_SEQ_ACCENT_EN
  localparam int DW = 6;
`else
  localparam int DW = 5;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic          restart = 1'b0;
  logic [15:0]   tempo = 16'd9;
  logic [7:0]    gate_len = 8'd2;
  logic [2:0]    last_step = 3'd3;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          pluck;
  logic [3:0]    period;
  logic [2:0]    step;
  logic          tick;
  logic          busy;
`ifdef KS_SEQ_ACCENT_EN
  logic          accent;
`endif

  ks_note_sequencer #(.NUM_STEPS(8), .PERIOD_W(4), .TEMPO_W(16), .GATE_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .restart_i(restart),
    .tempo_i(tempo), .gate_len_i(gate_len), .last_step_i(last_step),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .pluck_o(pluck), .period_o(period), .step_o(step), .step_tick_o(tick), .busy_o(busy)
`ifdef KS_SEQ_ACCENT_EN
    , .accent_o(accent)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the running step and the position within it.
  bit [DW-1:0] m_mem [8];
  bit m_run, m_rest, m_acc, e_tick, e_pluck;
  int m_step, m_pos, m_per, t_eff, hi;

  task start_step(input int s);
    m_run  = 1'b1;
    m_step = s;
    m_pos  = 0;
    m_per  = int'(m_mem[s][3:0]);
    m_rest = m_mem[s][4];
`ifdef KS_SEQ_ACCENT_EN
    m_acc  = m_mem[s][5];
`endif
    e_tick  = 1'b1;
    e_pluck = !m_rest;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_mem[i] = '0;
      m_run = 0; m_rest = 0; m_acc = 0; e_tick = 0; e_pluck = 0;
      m_step = 0; m_pos = 0; m_per = 0;
    end else begin
      t_eff = (tempo == 16'd0) ? 1 : int'(tempo);
      hi = (int'(gate_len) + 1 < t_eff) ? int'(gate_len) + 1 : t_eff;
      e_tick = 1'b0;
      if (!enable) begin
        m_run = 1'b0;
        e_pluck = 1'b0;
      end else if (!m_run || restart) begin
        start_step(0);
      end else if (m_pos >= t_eff) begin
        start_step((m_step >= int'(last_step)) ? 0 : m_step + 1);
      end else begin
        m_pos++;
        e_pluck = !m_rest && (m_pos < hi);
      end
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("tick", int'(tick), int'(e_tick));
      chk("pluck", int'(pluck), int'(e_pluck));
      chk("period", int'(period), m_per);
      chk("step", int'(step), m_step);
      chk("busy", int'(busy), int'(m_run));
`ifdef KS_SEQ_ACCENT_EN
      chk("accent", int'(accent), int'(m_acc));
`endif
    end
  end

  function automatic logic [DW-1:0] mk(input bit acc, input bit rest, input int per);
    logic [5:0] v;
    v = {acc, rest, per[3:0]};
    return v[DW-1:0];
  endfunction

  int k;
  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask
  task automatic run_to(input int target);
    while (k < target) begin
      step_clk();
      k++;
    end
  endtask

  int per_tab [4] = '{3, 5, 7, 9};
  int tick_at [8];
  int tick_per [8];
  int nt, cnt, per10, tick10;
  logic [9:0] pat;

  initial begin
    // Reset with enable held high
    enable = 1'b1;
    #1 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (3) step_clk();
    chk("rst_pluck", int'(pluck), 0);
    chk("rst_period", int'(period), 0);
    rst_n = 1'b1;
    step_clk();
    chk("first_tick", int'(tick), 1);
    chk("first_step", int'(step), 0);

    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = mk(0, 0, per_tab[i]);
      step_clk();
    end
    wr_en = 1'b0;
    step_clk();

    // Four-step pattern, tempo 9, gate 2
    enable = 1'b1; nt = 0; cnt = 0;
    for (int j = 0; j <= 40; j++) begin
      step_clk();
      if (tick && nt < 8) begin tick_at[nt] = j; tick_per[nt] = int'(period); nt++; end
      if (j < 10 && pluck) cnt++;
    end
    chk("t2_ntick", nt, 5);
    for (int j = 0; j < 5; j++) begin
      chk("t2_tick_pos", tick_at[j], j * 10);
      chk("t2_period", tick_per[j], (j == 4) ? 3 : per_tab[j]);
    end
    chk("t2_pluck_len", cnt, 3);
    enable = 1'b0;
    step_clk();

    // Rest on step 1
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = mk(0, 1, 5);
    step_clk();
    wr_en = 1'b0; enable = 1'b1; cnt = 0; per10 = 0; tick10 = 0;
    for (int j = 0; j < 20; j++) begin
      step_clk();
      if (j >= 10 && pluck) cnt++;
      if (j == 10) begin per10 = int'(period); tick10 = int'(tick); end
    end
    chk("t3_rest_pluck", cnt, 0);
    chk("t3_rest_period", per10, 5);
    chk("t3_rest_tick", tick10, 1);
    enable = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = mk(0, 0, 5);
    step_clk();
    wr_en = 1'b0;

    // Long gate clipped by short tempo
    tempo = 16'd4; gate_len = 8'd50; enable = 1'b1; pat = '0;
    for (int j = 0; j < 10; j++) begin
      step_clk();
      pat[9-j] = pluck;
    end
    chk("t4_pattern", int'(pat), int'(10'b1111011110));
    enable = 1'b0;
    step_clk();
    tempo = 16'd9; gate_len = 8'd2;

    // Restart during step 2 gate, then disable beating restart
    enable = 1'b1; k = -1;
    run_to(21);
    restart = 1'b1;
    step_clk();
    restart = 1'b0;
    chk("t5_step", int'(step), 0);
    chk("t5_tick", int'(tick), 1);
    chk("t5_period", int'(period), 3);
    chk("t5_pluck", int'(pluck), 1);
    enable = 1'b0; restart = 1'b1;
    step_clk();
    restart = 1'b0;
    chk("t5_off_pluck", int'(pluck), 0);
    chk("t5_off_busy", int'(busy), 0);

    // Overwrite the active step
    enable = 1'b1; k = -1;
    run_to(21);
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = mk(0, 0, 12);
    step_clk(); k++;
    wr_en = 1'b0;
    run_to(25);
    chk("t6_keep", int'(period), 7);
    run_to(60);
    chk("t6_new", int'(period), 12);
    chk("t6_step", int'(step), 2);
    enable = 1'b0;
    step_clk();

`ifdef KS_SEQ_ACCENT_EN
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = mk(1, 0, 3);
    step_clk();
    wr_en = 1'b0; enable = 1'b1; k = -1;
    run_to(5);
    chk("acc_step0", int'(accent), 1);
    run_to(15);
    chk("acc_step1", int'(accent), 0);
    enable = 1'b0;
    step_clk();
`endif

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_pluck", int'(pluck), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_period", int'(period), 0);
        chk("async_step", int'(step), 0);
        step_clk();
        rst_n = 1'b1;
      end else begin
        enable  = ($urandom_range(0, 19) != 0);
        restart = ($urandom_range(0, 29) == 0);
        wr_en   = ($urandom_range(0, 3) == 0);
        wr_addr = 3'($urandom_range(0, 7));
        wr_data = DW'($urandom);
        if ($urandom_range(0, 49) == 0) last_step = 3'($urandom_range(0, 7));
        if (!enable) begin
          tempo    = 16'($urandom_range(0, 6));
          gate_len = 8'($urandom_range(0, 7));
        end
        step_clk();
      end
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
